// File: rtl/codec_init_pkg.sv
// codec_init_pkg: shared types and constants for the WM8731 init sequencer.
// Holds the FSM state enum, the I2C command width, the codec device address
// and the fixed command table walked after power-up.
// Optional build macro used by the users of this package: CFG_RETRY_EN.
package codec_init_pkg;

  localparam int CMD_W = 24;
  localparam int CMD_TABLE_LEN = 16;
  localparam logic [7:0] DEV_ADDR = 8'h34;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  // Each word is {device address, reg[6:0], data[8], data[7:0]}.
  // Only the first seven entries are part of the power-up sequence; the spare
  // slots repeat the "active" command so an oversized NUM_CMD stays harmless.
  localparam logic [CMD_W-1:0] CMD_TABLE [CMD_TABLE_LEN] = '{
    {DEV_ADDR, 16'h1E00},  // reset
    {DEV_ADDR, 16'h0815},  // analog audio path
    {DEV_ADDR, 16'h0A00},  // digital audio path
    {DEV_ADDR, 16'h0C00},  // power down control, everything on
    {DEV_ADDR, 16'h0E42},  // I2S, master, 16 bit
    {DEV_ADDR, 16'h1019},  // sampling control
    {DEV_ADDR, 16'h1201},  // active
    {DEV_ADDR, 16'h1201},
    {DEV_ADDR, 16'h1201},
    {DEV_ADDR, 16'h1201},
    {DEV_ADDR, 16'h1201},
    {DEV_ADDR, 16'h1201},
    {DEV_ADDR, 16'h1201},
    {DEV_ADDR, 16'h1201},
    {DEV_ADDR, 16'h1201},
    {DEV_ADDR, 16'h1201}
  };

endpackage

// File: rtl/codec_init_ctrl_if.sv
// codec_init_ctrl_if: handshake between the init sequencer and I2cSender.
// The sequencer is the master (drives start/dat), the sender is the slave.
// With CFG_RETRY_EN defined the sender also reports a NACK flag.
interface codec_init_ctrl_if;
  import codec_init_pkg::*;

  logic             start;
  logic [CMD_W-1:0] dat;
  logic             finished;
`ifdef CFG_RETRY_EN
  logic             nack;
`endif

`ifdef CFG_RETRY_EN
  modport master (output start, output dat, input finished, input nack);
  modport slave  (input start, input dat, output finished, output nack);
`else
  modport master (output start, output dat, input finished);
  modport slave  (input start, input dat, output finished);
`endif

endinterface

// File: rtl/codec_cmd_rom.sv
// codec_cmd_rom: combinational index -> 24-bit command word lookup.
// The contents come straight from the package table so the sequencer and
// any other user of the table can never disagree about the command list.
module codec_cmd_rom
  import codec_init_pkg::*;
(
  input  logic [3:0]       i_idx,
  output logic [CMD_W-1:0] o_word
);

  assign o_word = CMD_TABLE[i_idx];

endmodule

// File: rtl/codec_init_ctrl.sv
// codec_init_ctrl: sequences I2cSender through the WM8731 command table.
// On an accepted i_start it loads each table word, pulses the sender's start,
// waits for finished (bounded by a timeout), idles for GAP_CYC cycles and
// moves on. Reports busy/done/err levels to the top.
// Build macro CFG_RETRY_EN: adds the sender NACK input and per-command retries
// (up to MAX_RETRY) before giving up with an error.
module codec_init_ctrl
  import codec_init_pkg::*;
#(
  parameter int NUM_CMD     = 7,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 100000
`ifdef CFG_RETRY_EN
  ,
  parameter int MAX_RETRY   = 3
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [3:0]        o_cmd_idx,
  codec_init_ctrl_if.master io_i2c
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
`ifdef CFG_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`endif

  state_t           r_state;
  state_t           w_nextState;
  logic [3:0]       r_idx;
  logic [GAP_W-1:0] r_gapCnt;
  logic [TO_W-1:0]  r_toCnt;
  logic [CMD_W-1:0] r_dat;
  logic [CMD_W-1:0] w_romWord;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_i2cStart;

  logic w_accept;
  logic w_gapDone;
  logic w_timeout;
  logic w_lastCmd;
  logic w_repeatNow;
  logic w_advance;

`ifdef CFG_RETRY_EN
  logic [RETRY_W-1:0] r_retryCnt;
  logic               r_repeat;
  logic               w_retryExhausted;
  logic               w_nackRetry;
`endif

  codec_cmd_rom u_rom (
    .i_idx  (r_idx),
    .o_word (w_romWord)
  );

  // A start request is only honoured from a resting state; while busy it is dropped.
  assign w_accept  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                 (r_state == ST_ERROR));
  assign w_gapDone = (r_gapCnt == GAP_W'(GAP_CYC - 1));
  assign w_timeout = (r_toCnt == TO_W'(TIMEOUT_CYC - 1));
  assign w_lastCmd = (r_idx == 4'(NUM_CMD - 1));

`ifdef CFG_RETRY_EN
  assign w_retryExhausted = (r_retryCnt == RETRY_W'(MAX_RETRY));
  assign w_nackRetry      = (r_state == ST_WAIT) && io_i2c.finished && io_i2c.nack &&
                            !w_retryExhausted;
  assign w_repeatNow      = r_repeat;
`else
  assign w_repeatNow      = 1'b0;
`endif

  // The index only moves forward at the end of a gap that is not a retry.
  assign w_advance = (r_state == ST_GAP) && w_gapDone && !w_repeatNow && !w_lastCmd;

  // State register; reset aborts any transfer in flight because the sender resets too.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic for the load/start/wait/gap walk through the table.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (w_accept) w_nextState = ST_LOAD;
      end
      ST_LOAD:  w_nextState = ST_START;
      ST_START: w_nextState = ST_WAIT;
      ST_WAIT: begin
        if (io_i2c.finished) begin
`ifdef CFG_RETRY_EN
          if (io_i2c.nack && w_retryExhausted) w_nextState = ST_ERROR;
          else                                 w_nextState = ST_GAP;
`else
          w_nextState = ST_GAP;
`endif
        end else if (w_timeout) begin
          w_nextState = ST_ERROR;
        end
      end
      ST_GAP: begin
        if (w_gapDone) begin
          if (w_repeatNow)    w_nextState = ST_LOAD;
          else if (w_lastCmd) w_nextState = ST_DONE;
          else                w_nextState = ST_LOAD;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Status and start-pulse registers follow the state being entered, so they
  // change on the same edge as the state itself and never glitch.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_i2cStart <= 1'b0;
    end else begin
      r_busy     <= (w_nextState == ST_LOAD) || (w_nextState == ST_START) ||
                    (w_nextState == ST_WAIT) || (w_nextState == ST_GAP);
      r_done     <= (w_nextState == ST_DONE);
      r_err      <= (w_nextState == ST_ERROR);
      r_i2cStart <= (w_nextState == ST_START);
    end
  end

  // Command index: restarts at zero on every accepted request.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_idx <= 4'd0;
    end else if (w_accept) begin
      r_idx <= 4'd0;
    end else if (w_advance) begin
      r_idx <= r_idx + 4'd1;
    end
  end

  // Command word is captured in LOAD and then held steady for the whole transfer.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_dat <= CMD_TABLE[0];
    end else if (r_state == ST_LOAD) begin
      r_dat <= w_romWord;
    end
  end

  // Inter-command gap counter; runs only inside GAP and stops at its limit.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_gapCnt <= '0;
    end else if (r_state == ST_GAP) begin
      if (!w_gapDone) r_gapCnt <= r_gapCnt + 1'b1;
    end else begin
      r_gapCnt <= '0;
    end
  end

  // Timeout counter measures cycles since the start pulse (zero during START).
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_toCnt <= '0;
    end else if ((r_state == ST_START) || (r_state == ST_WAIT)) begin
      if (!w_timeout) r_toCnt <= r_toCnt + 1'b1;
    end else begin
      r_toCnt <= '0;
    end
  end

`ifdef CFG_RETRY_EN
  // Retry bookkeeping: a NACK with budget left re-issues the same index after a gap.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_retryCnt <= '0;
      r_repeat   <= 1'b0;
    end else if (w_accept || w_advance) begin
      r_retryCnt <= '0;
      r_repeat   <= 1'b0;
    end else if (w_nackRetry) begin
      r_retryCnt <= r_retryCnt + 1'b1;
      r_repeat   <= 1'b1;
    end else if (r_state == ST_LOAD) begin
      r_repeat   <= 1'b0;
    end
  end
`endif

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_cmd_idx  = r_idx;
  assign io_i2c.start = r_i2cStart;
  assign io_i2c.dat   = r_dat;

endmodule
